// File: rtl/varredura_sonar.sv
// varredura_sonar: ping-pong sweep sequencer (0..7..0) for the sonar servo.
// At each position: settle, trigger one measurement, wait for it, then
// pulse transmitir and step to the next position.
// Optional feature macro: VARREDURA_TIMEOUT_EN -- abandons a measurement
// after T_TIMEOUT cycles in ESPERA and pulses timeout.
module varredura_sonar #(
  parameter int T_ASSENTAMENTO = 10_000_000,
  parameter int T_TIMEOUT      = 2_500_000
) (
  input  logic       clock,
  input  logic       reset,       // asynchronous, active low
  input  logic       ligar,
  input  logic       fim_medida,
  output logic [2:0] posicao,
  output logic       sentido,
  output logic       medir,
  output logic       transmitir,
  output logic       timeout
);

  // One counter serves both the settle wait and the measurement timeout.
  localparam int TMAX = (T_ASSENTAMENTO > T_TIMEOUT) ? T_ASSENTAMENTO : T_TIMEOUT;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    INICIAL,
    ASSENTA,
    MEDE,
    ESPERA,
    TRANSMITE,
    AVANCA
  } estado_t;

  estado_t       state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    pos_q, pos_d;
  logic          sent_q, sent_d;
  logic          medir_q, trans_q;
`ifdef VARREDURA_TIMEOUT_EN
  logic          tmo_q;
`endif

  // Next sweep position: bounce at the endpoints so 0 and 7 are visited once per turn.
  always_comb begin
    pos_d  = pos_q;
    sent_d = sent_q;
    if (!sent_q) begin
      if (pos_q == 3'd7) begin
        sent_d = 1'b1;
        pos_d  = 3'd6;
      end else begin
        pos_d = pos_q + 3'd1;
      end
    end else begin
      if (pos_q == 3'd0) begin
        sent_d = 1'b0;
        pos_d  = 3'd1;
      end else begin
        pos_d = pos_q - 3'd1;
      end
    end
  end

  // Sweep FSM; pulse outputs are registered alongside the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      cnt_q   <= '0;
      pos_q   <= 3'd0;
      sent_q  <= 1'b0;
      medir_q <= 1'b0;
      trans_q <= 1'b0;
`ifdef VARREDURA_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      medir_q <= 1'b0;
      trans_q <= 1'b0;
`ifdef VARREDURA_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
      case (state_q)
        INICIAL: begin
          if (ligar) begin
            state_q <= ASSENTA;
            cnt_q   <= '0;
          end
        end
        ASSENTA: begin
          // Dropping ligar abandons the settle; position is kept for resume.
          if (!ligar) begin
            state_q <= INICIAL;
          end else if (cnt_q == CW'(T_ASSENTAMENTO - 1)) begin
            state_q <= MEDE;
            medir_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        MEDE: begin
          state_q <= ESPERA;
          cnt_q   <= '0;
        end
        ESPERA: begin
          // ligar is deliberately ignored: a started measurement completes.
          if (fim_medida) begin
            state_q <= TRANSMITE;
            trans_q <= 1'b1;
          end
`ifdef VARREDURA_TIMEOUT_EN
          else if (cnt_q == CW'(T_TIMEOUT - 1)) begin
            state_q <= AVANCA;
            tmo_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        TRANSMITE: begin
          state_q <= AVANCA;
        end
        AVANCA: begin
          pos_q  <= pos_d;
          sent_q <= sent_d;
          if (ligar) begin
            state_q <= ASSENTA;
            cnt_q   <= '0;
          end else begin
            state_q <= INICIAL;
          end
        end
        default: state_q <= INICIAL;
      endcase
    end
  end

  assign posicao    = pos_q;
  assign sentido    = sent_q;
  assign medir      = medir_q;
  assign transmitir = trans_q;
`ifdef VARREDURA_TIMEOUT_EN
  assign timeout    = tmo_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_varredura_sonar.sv
// Bench for varredura_sonar: the stimulus script pushes the expected pulse
// events (kind, posicao, sentido, cycle) into a queue; a negedge monitor pops
// and compares whenever medir, transmitir or timeout is seen.
module tb_varredura_sonar;

  localparam int TA = 10;
  localparam int TT = 20;
  localparam int K_MEDIR = 0, K_TRANS = 1, K_TMO = 2;

  logic       clock, reset, ligar, fim_medida;
  logic [2:0] posicao;
  logic       sentido, medir, transmitir, timeout;

  varredura_sonar #(.T_ASSENTAMENTO(TA), .T_TIMEOUT(TT)) dut (
    .clock      (clock),
    .reset      (reset),
    .ligar      (ligar),
    .fim_medida (fim_medida),
    .posicao    (posicao),
    .sentido    (sentido),
    .medir      (medir),
    .transmitir (transmitir),
    .timeout    (timeout)
  );

  typedef struct {
    int kind;
    int pos;
    int sent;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  next_m  = 0;

  // Positions visited with a measurement, in run order, and their direction.
  int P[24] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1, 2, 3,4,5,6,7,6, 5};
  int S[24] = '{0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,0, 0, 0,0,0,0,0,1, 1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int pos, input int sent, input int c);
    ev_t e;
    e.kind = kind; e.pos = pos; e.sent = sent; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input string nm);
    ev_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected pulse at cycle %0d pos=%0d", nm, cyc, posicao);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.pos != int'(posicao) || e.sent != int'(sentido) || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d pos=%0d sent=%0d cyc=%0d, expected kind=%0d pos=%0d sent=%0d cyc=%0d",
                 nm, kind, posicao, sentido, cyc, e.kind, e.pos, e.sent, e.cyc);
      end
    end
  endtask

  // Monitor: every pulse must match the next expected event.
  always @(negedge clock) begin
    if (reset) begin
      if (medir || transmitir) begin
        n_tests++;
        if (medir && transmitir) begin
          n_fail++;
          $display("FAIL excl: medir and transmitir both high at cycle %0d", cyc);
        end
      end
      if (medir)      pop_chk(K_MEDIR, "medir");
      if (transmitir) pop_chk(K_TRANS, "transmitir");
      if (timeout)    pop_chk(K_TMO, "timeout");
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  // One measurement at run index i; fim_medida returned 3 cycles after medir.
  task automatic meas(input int i, input bit drop);
    push(K_MEDIR, P[i], S[i], next_m);
    push(K_TRANS, P[i], S[i], next_m + 4);
    wait_until(next_m + 1);
    if (drop) ligar = 1'b0;
    wait_until(next_m + 3);
    fim_medida = 1'b1;
    tick();
    fim_medida = 1'b0;
    wait_until(next_m + 6);
    chk("posicao_next", int'(posicao), P[i+1]);
    chk("sentido_next", int'(sentido), S[i+1]);
    next_m += 16;
  endtask

  initial begin
    int m;
    reset = 1'b0; ligar = 1'b0; fim_medida = 1'b0;
    #2;
    chk("rst_posicao", int'(posicao), 0);
    chk("rst_medir", int'(medir), 0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // Full sweep 0..7..0,1 with ligar held high
    ligar  = 1'b1;
    next_m = cyc + 11;
    for (int i = 0; i < 16; i++) meas(i, 1'b0);

    // Disable during ESPERA at posicao 2: measurement still completes
    meas(16, 1'b1);
    idle(3);
    fim_medida = 1'b1;   // must be ignored in INICIAL
    tick();
    fim_medida = 1'b0;
    idle(15);
    chk("idle_posicao", int'(posicao), 3);

    // Pause during ASSENTA at posicao 3, then resume with a full settle
    ligar = 1'b1;
    idle(4);
    ligar = 1'b0;
    idle(20);
    chk("pause_posicao", int'(posicao), 3);
    chk("pause_sentido", int'(sentido), 0);
    ligar  = 1'b1;
    next_m = cyc + 11;
    for (int i = 17; i < 23; i++) meas(i, 1'b0);

    // Asynchronous reset mid-ESPERA at posicao 5, sentido 1
    push(K_MEDIR, P[23], S[23], next_m);
    wait_until(next_m + 2);
    chk("pre_rst_posicao", int'(posicao), 5);
    reset = 1'b0;
    ligar = 1'b0;
    #1;
    chk("arst_posicao", int'(posicao), 0);
    chk("arst_sentido", int'(sentido), 0);
    chk("arst_pulses", int'({medir, transmitir, timeout}), 0);
    idle(2);
    reset = 1'b1;
    idle(20);
    chk("post_rst_posicao", int'(posicao), 0);

    // Measurement that never completes
    ligar = 1'b1;
    m     = cyc + 11;
    push(K_MEDIR, 0, 0, m);
`ifdef VARREDURA_TIMEOUT_EN
    push(K_TMO, 0, 0, m + 21);
    wait_until(m + 22);
    chk("tmo_posicao", int'(posicao), 1);
    ligar = 1'b0;
    idle(5);
`else
    wait_until(m + 1000);
    chk("wait_posicao", int'(posicao), 0);
    chk("wait_timeout", int'(timeout), 0);
`endif
    idle(5);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
